// File: rtl/ifu32_fetch_if.sv
// rtl/ifu32_fetch_if.sv - fetch unit bundle: imem req/rsp, EXU redirect, IDU instruction handshake
`timescale 1ns/1ps
interface ifu32_fetch_if;
  // instruction memory request channel
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  // instruction memory response channel
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  // execute-stage redirect
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  // decoder handshake
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
`ifdef IFU_MISALIGN_EN
  logic        fetch_misalign;
`endif

  // fetch unit side
  modport master (
    output imem_req_valid,
    input  imem_req_ready,
    output imem_req_addr,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    input  redirect_valid,
    input  redirect_pc,
    output inst_valid,
    input  inst_ready,
    output inst,
    output inst_pc
`ifdef IFU_MISALIGN_EN
    , output fetch_misalign
`endif
  );

  // memory / EXU / IDU side
  modport slave (
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_req_addr,
    output imem_rsp_valid,
    output imem_rsp_data,
    output redirect_valid,
    output redirect_pc,
    input  inst_valid,
    output inst_ready,
    input  inst,
    input  inst_pc
`ifdef IFU_MISALIGN_EN
    , input fetch_misalign
`endif
  );
endinterface

// File: rtl/ifu32_fetch.sv
// rtl/ifu32_fetch.sv - single-outstanding instruction fetch FSM; IFU_MISALIGN_EN adds the FAULT state
`timescale 1ns/1ps
module ifu32_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input logic           clk,
  input logic           rst,
  ifu32_fetch_if.master bus
);

`ifdef IFU_MISALIGN_EN
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN, FAULT} state_t;
`else
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_t;
`endif

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic [31:0] redir_target;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;
  logic        req_valid_q;
  logic        inst_valid_q;
  logic        take_rsp;
`ifdef IFU_MISALIGN_EN
  logic        redir_bad;
  logic        fault_q;
  logic        inflight_q;
  logic        inflight_nxt;
`endif

  // Redirect target as it will be loaded into pc; without the fault feature the low bits are dropped.
`ifdef IFU_MISALIGN_EN
  assign redir_target = bus.redirect_pc;
  assign redir_bad    = |bus.redirect_pc[1:0];
`else
  assign redir_target = bus.redirect_pc & 32'hFFFF_FFFC;
`endif

  // Next state and next pc; a redirect overrides every other event in the current state.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    take_rsp  = 1'b0;
    if (bus.redirect_valid) begin
      pc_nxt = redir_target;
      case (state)
        IDLE:  state_nxt = REQ;
        // a request accepted on this edge is already in memory and must be drained
        REQ:   state_nxt = bus.imem_req_ready ? DRAIN : REQ;
        WAIT:  state_nxt = bus.imem_rsp_valid ? REQ : DRAIN;
        HOLD:  state_nxt = REQ;
        DRAIN: state_nxt = bus.imem_rsp_valid ? REQ : DRAIN;
`ifdef IFU_MISALIGN_EN
        FAULT: state_nxt = (inflight_q && !bus.imem_rsp_valid) ? DRAIN : REQ;
`endif
        default: state_nxt = IDLE;
      endcase
`ifdef IFU_MISALIGN_EN
      if (redir_bad) begin
        state_nxt = FAULT;
      end
`endif
    end else begin
      case (state)
        IDLE:  state_nxt = REQ;
        REQ:   if (bus.imem_req_ready) state_nxt = WAIT;
        WAIT: begin
          if (bus.imem_rsp_valid) begin
            take_rsp  = 1'b1;
            state_nxt = HOLD;
          end
        end
        HOLD: begin
          if (bus.inst_ready) begin
            pc_nxt    = pc + 32'd4;
            state_nxt = REQ;
          end
        end
        DRAIN: if (bus.imem_rsp_valid) state_nxt = REQ;
`ifdef IFU_MISALIGN_EN
        FAULT: state_nxt = FAULT;
`endif
        default: state_nxt = IDLE;
      endcase
    end
  end

`ifdef IFU_MISALIGN_EN
  // Whether a memory response is still owed after this edge; decides DRAIN vs REQ when leaving FAULT.
  always_comb begin
    inflight_nxt = 1'b0;
    case (state)
      REQ:         inflight_nxt = bus.imem_req_ready;
      WAIT, DRAIN: inflight_nxt = !bus.imem_rsp_valid;
      FAULT:       inflight_nxt = inflight_q && !bus.imem_rsp_valid;
      default:     inflight_nxt = 1'b0;
    endcase
  end
`endif

  // State, pc, instruction capture and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= 32'd0;
      inst_pc_q    <= 32'd0;
`ifdef IFU_MISALIGN_EN
      fault_q      <= 1'b0;
      inflight_q   <= 1'b0;
`endif
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      req_valid_q  <= (state_nxt == REQ);
      inst_valid_q <= (state_nxt == HOLD);
      if (take_rsp) begin
        inst_q    <= bus.imem_rsp_data;
        inst_pc_q <= pc;
      end
`ifdef IFU_MISALIGN_EN
      fault_q      <= (state_nxt == FAULT);
      inflight_q   <= inflight_nxt;
`endif
    end
  end

  assign bus.imem_req_valid = req_valid_q;
  assign bus.imem_req_addr  = pc;
  assign bus.inst_valid     = inst_valid_q;
  assign bus.inst           = inst_q;
  assign bus.inst_pc        = inst_pc_q;
`ifdef IFU_MISALIGN_EN
  assign bus.fetch_misalign = fault_q;
`endif

endmodule
